position_tracker_quad: RTL and testbench

- Parametrised successor of the single-channel fringe counter.
- Takes a packed two-channel (A/B) signed sample stream and applies an independent hysteresis comparator (Schmitt trigger) to each channel.
- Accumulates a signed fringe position in one of two modes: legacy single-channel counting, or quadrature decoding with direction derived from A/B phase.
- Sits between the demodulation/filter chain and the position DMA/readout path; also reports illegal quadrature transitions.

---
 rtl/position_tracker_quad.sv | 227 ++++++++++++++++++++++
 tb/tb_position_tracker_quad.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/position_tracker_quad.sv
// position_tracker_quad
// Two-channel fringe position tracker. Each channel (A/B) passes through its
// own Schmitt trigger; the resulting logic levels drive either a legacy
// single-channel fringe counter (channel A falling edges) or a quadrature
// decoder that also counts illegal double transitions. Position and error
// count are registered and presented one cycle after each accepted sample.
module position_tracker_quad #(
    parameter int DATA_WIDTH     = 16,
    parameter int POSITION_WIDTH = 32,
    parameter int ERROR_WIDTH    = 16,
    parameter int SATURATE       = 0
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_reset,
    input  logic                        FC_mode,
    input  logic                        FC_sign,
    input  logic                        FC_clear,
    input  logic [DATA_WIDTH-1:0]       FC_lower_treshold,
    input  logic [DATA_WIDTH-1:0]       FC_upper_treshold,
    input  logic                        S_AXIS_tvalid,
    input  logic [2*DATA_WIDTH-1:0]     S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [POSITION_WIDTH-1:0]   M_AXIS_tdata,
    output logic [ERROR_WIDTH-1:0]      ST_error_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } cmp_state_t;

    localparam logic signed [POSITION_WIDTH-1:0] POS_MAX = {1'b0, {(POSITION_WIDTH-1){1'b1}}};
    localparam logic signed [POSITION_WIDTH-1:0] POS_MIN = {1'b1, {(POSITION_WIDTH-1){1'b0}}};
    localparam logic signed [POSITION_WIDTH-1:0] POS_ONE = POSITION_WIDTH'(1);
    localparam logic [ERROR_WIDTH-1:0]           ERR_ONE = ERROR_WIDTH'(1);
    localparam logic [ERROR_WIDTH-1:0]           ERR_MAX = {ERROR_WIDTH{1'b1}};

    // Hysteresis comparator transition. The "below lower" test is checked
    // first from IDLE so that inverted thresholds resolve deterministically.
    function automatic cmp_state_t cmp_next(
        input cmp_state_t                    cur,
        input logic signed [DATA_WIDTH-1:0]  x,
        input logic signed [DATA_WIDTH-1:0]  lo,
        input logic signed [DATA_WIDTH-1:0]  hi
    );
        cmp_state_t nxt;
        nxt = cur;
        case (cur)
            ST_IDLE: begin
                if (x < lo) begin
                    nxt = ST_LOW;
                end else if (x > hi) begin
                    nxt = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (x > hi) begin
                    nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (x < lo) begin
                    nxt = ST_LOW;
                end
            end
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    // Gray code {B,A} to its ordinal along the forward sequence 00,01,11,10.
    function automatic logic [1:0] quad_index(input logic [1:0] code);
        return {code[1], code[1] ^ code[0]};
    endfunction

    // One-step position update with either wrap or clamp at the signed limits.
    function automatic logic signed [POSITION_WIDTH-1:0] next_position(
        input logic signed [POSITION_WIDTH-1:0] pos,
        input logic                             up,
        input logic                             down
    );
        logic signed [POSITION_WIDTH-1:0] res;
        res = pos;
        if (up) begin
            if (!((SATURATE != 0) && (pos == POS_MAX))) begin
                res = pos + POS_ONE;
            end
        end else if (down) begin
            if (!((SATURATE != 0) && (pos == POS_MIN))) begin
                res = pos - POS_ONE;
            end
        end
        return res;
    endfunction

    // Error counter increment that sticks at all-ones.
    function automatic logic [ERROR_WIDTH-1:0] next_error(
        input logic [ERROR_WIDTH-1:0] cnt,
        input logic                   evt
    );
        logic [ERROR_WIDTH-1:0] res;
        res = cnt;
        if (evt && (cnt != ERR_MAX)) begin
            res = cnt + ERR_ONE;
        end
        return res;
    endfunction

    logic signed [DATA_WIDTH-1:0]     sample_a;
    logic signed [DATA_WIDTH-1:0]     sample_b;
    logic signed [DATA_WIDTH-1:0]     lower;
    logic signed [DATA_WIDTH-1:0]     upper;

    cmp_state_t                       state_a_p1;
    cmp_state_t                       state_b_p1;
    cmp_state_t                       state_a_next;
    cmp_state_t                       state_b_next;
    logic                             mode_p1;
    logic [1:0]                       prev_code_p1;
    logic [1:0]                       prev_code_next;
    logic                             prev_valid_p1;
    logic                             prev_valid_next;

    logic                             mode_changed;
    logic                             code_valid;
    logic [1:0]                       new_code;
    logic [1:0]                       quad_delta;
    logic                             fwd_step;
    logic                             rev_step;
    logic                             illegal_step;
    logic                             step_up;
    logic                             step_down;

    logic signed [POSITION_WIDTH-1:0] position_p1;
    logic [ERROR_WIDTH-1:0]           error_count_p1;
    logic                             vld_p1;

    assign sample_a     = $signed(S_AXIS_tdata[DATA_WIDTH-1:0]);
    assign sample_b     = $signed(S_AXIS_tdata[2*DATA_WIDTH-1:DATA_WIDTH]);
    assign lower        = $signed(FC_lower_treshold);
    assign upper        = $signed(FC_upper_treshold);
    assign mode_changed = (FC_mode != mode_p1);

    // Next comparator states, quadrature decode and previous-code bookkeeping.
    always_comb begin
        state_a_next    = state_a_p1;
        state_b_next    = state_b_p1;
        prev_code_next  = prev_code_p1;
        prev_valid_next = prev_valid_p1 & ~mode_changed;
        code_valid      = 1'b0;
        new_code        = 2'b00;
        quad_delta      = 2'b00;
        fwd_step        = 1'b0;
        rev_step        = 1'b0;
        illegal_step    = 1'b0;
        if (S_AXIS_tvalid) begin
            state_a_next = cmp_next(state_a_p1, sample_a, lower, upper);
            state_b_next = cmp_next(state_b_p1, sample_b, lower, upper);
            code_valid   = (state_a_next != ST_IDLE) && (state_b_next != ST_IDLE);
            new_code     = {state_b_next == ST_HIGH, state_a_next == ST_HIGH};
            quad_delta   = quad_index(new_code) - quad_index(prev_code_p1);
            if (!FC_mode) begin
                fwd_step = (state_a_p1 == ST_HIGH) && (state_a_next == ST_LOW);
            end else if (code_valid && prev_valid_p1 && !mode_changed) begin
                // A just-invalidated previous code (mode change) must only load.
                case (quad_delta)
                    2'd1:    fwd_step     = 1'b1;
                    2'd2:    illegal_step = 1'b1;
                    2'd3:    rev_step     = 1'b1;
                    default: ;
                endcase
            end
            if (code_valid) begin
                prev_code_next  = new_code;
                prev_valid_next = 1'b1;
            end
        end
    end

    assign step_up   = FC_sign ? fwd_step : rev_step;
    assign step_down = FC_sign ? rev_step : fwd_step;

    // Comparator states, registered mode copy and previous-code register.
    always_ff @(posedge SYS_aclk) begin
        if (SYS_reset) begin
            state_a_p1    <= ST_IDLE;
            state_b_p1    <= ST_IDLE;
            mode_p1       <= 1'b0;
            prev_code_p1  <= 2'b00;
            prev_valid_p1 <= 1'b0;
        end else begin
            state_a_p1    <= state_a_next;
            state_b_p1    <= state_b_next;
            mode_p1       <= FC_mode;
            prev_code_p1  <= prev_code_next;
            prev_valid_p1 <= prev_valid_next;
        end
    end

    // Position and error accumulators; clear overrides any step this cycle.
    always_ff @(posedge SYS_aclk) begin
        if (SYS_reset || FC_clear) begin
            position_p1    <= '0;
            error_count_p1 <= '0;
        end else begin
            position_p1    <= next_position(position_p1, step_up, step_down);
            error_count_p1 <= next_error(error_count_p1, illegal_step);
        end
    end

    // Output valid follows each accepted sample by one cycle.
    always_ff @(posedge SYS_aclk) begin
        if (SYS_reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= S_AXIS_tvalid;
        end
    end

    assign S_AXIS_tready  = 1'b1;
    assign M_AXIS_tvalid  = vld_p1;
    assign M_AXIS_tdata   = position_p1;
    assign ST_error_count = error_count_p1;

endmodule

// File: tb/tb_position_tracker_quad.sv
// Testbench for position_tracker_quad: a default 32-bit instance plus two
// 8-bit instances (wrapping and saturating, 8-bit error counter) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_position_tracker_quad;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode;
    logic               sign;
    logic               clear;
    logic signed [15:0] lo_t;
    logic signed [15:0] hi_t;
    logic               tvalid;
    logic [31:0]        tdata;

    logic        rdy32, rdy8w, rdy8s;
    logic        vld32, vld8w, vld8s;
    logic [31:0] pos32;
    logic [7:0]  pos8w, pos8s;
    logic [15:0] err16;
    logic [7:0]  err8w, err8s;

    int total = 0;
    int bad   = 0;

    int cur_a = 0;
    int cur_b = 0;

    // behavioural model state: 0 = idle, 1 = low, 2 = high
    int     m_a, m_b, m_prev, m_pos8s, m_err;
    bit     m_prev_ok, m_vld, m_last_mode;
    longint m_pos;
    int     seq_pos[4] = '{0, 1, 3, 2};   // ordinal of each {B,A} code in 00,01,11,10
    int     fwd_next[4] = '{1, 3, 0, 2};
    int     rev_next[4] = '{2, 0, 3, 1};
    int     cur_code;

    typedef struct {
        int     a;
        int     b;
        bit     mode;
        bit     sign;
        bit     clr;
        longint exp_pos;
        int     exp_err;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    position_tracker_quad dut32 (
        .SYS_aclk(clk), .SYS_reset(rst), .FC_mode(mode), .FC_sign(sign), .FC_clear(clear),
        .FC_lower_treshold(lo_t), .FC_upper_treshold(hi_t),
        .S_AXIS_tvalid(tvalid), .S_AXIS_tdata(tdata), .S_AXIS_tready(rdy32),
        .M_AXIS_tvalid(vld32), .M_AXIS_tdata(pos32), .ST_error_count(err16));

    position_tracker_quad #(.POSITION_WIDTH(8), .ERROR_WIDTH(8), .SATURATE(0)) dut8w (
        .SYS_aclk(clk), .SYS_reset(rst), .FC_mode(mode), .FC_sign(sign), .FC_clear(clear),
        .FC_lower_treshold(lo_t), .FC_upper_treshold(hi_t),
        .S_AXIS_tvalid(tvalid), .S_AXIS_tdata(tdata), .S_AXIS_tready(rdy8w),
        .M_AXIS_tvalid(vld8w), .M_AXIS_tdata(pos8w), .ST_error_count(err8w));

    position_tracker_quad #(.POSITION_WIDTH(8), .ERROR_WIDTH(8), .SATURATE(1)) dut8s (
        .SYS_aclk(clk), .SYS_reset(rst), .FC_mode(mode), .FC_sign(sign), .FC_clear(clear),
        .FC_lower_treshold(lo_t), .FC_upper_treshold(hi_t),
        .S_AXIS_tvalid(tvalid), .S_AXIS_tdata(tdata), .S_AXIS_tready(rdy8s),
        .M_AXIS_tvalid(vld8s), .M_AXIS_tdata(pos8s), .ST_error_count(err8s));

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int hyst(input int st, input int x, input int lo, input int hi);
        if (st == 0) return (x < lo) ? 1 : ((x > hi) ? 2 : 0);
        if (st == 1) return (x > hi) ? 2 : 1;
        return (x < lo) ? 1 : 2;
    endfunction

    task automatic model_update();
        int na, nb, c, d, step;
        bit err_evt;
        step = 0;
        err_evt = 1'b0;
        if (rst) begin
            m_a = 0; m_b = 0; m_prev = 0; m_prev_ok = 1'b0;
            m_pos = 0; m_pos8s = 0; m_err = 0; m_vld = 1'b0;
        end else begin
            if (mode != m_last_mode) m_prev_ok = 1'b0;
            if (tvalid) begin
                na = hyst(m_a, cur_a, int'(lo_t), int'(hi_t));
                nb = hyst(m_b, cur_b, int'(lo_t), int'(hi_t));
                c = ((nb == 2) ? 2 : 0) + ((na == 2) ? 1 : 0);
                if (!mode) begin
                    if (m_a == 2 && na == 1) step = 1;
                end else if (na != 0 && nb != 0 && m_prev_ok) begin
                    d = (seq_pos[c] - seq_pos[m_prev] + 4) % 4;
                    if (d == 1) step = 1;
                    else if (d == 3) step = -1;
                    else if (d == 2) err_evt = 1'b1;
                end
                if (na != 0 && nb != 0) begin
                    m_prev = c;
                    m_prev_ok = 1'b1;
                end
                m_a = na;
                m_b = nb;
            end
            if (!sign) step = -step;
            if (clear) begin
                m_pos = 0; m_pos8s = 0; m_err = 0;
            end else begin
                m_pos = m_pos + step;
                m_pos8s = m_pos8s + step;
                if (m_pos8s > 127) m_pos8s = 127;
                if (m_pos8s < -128) m_pos8s = -128;
                if (err_evt) m_err++;
            end
            m_vld = tvalid;
        end
        m_last_mode = mode;
    endtask

    task automatic check_model();
        logic [31:0] e32;
        logic [7:0]  e8, e8s;
        e32 = m_pos[31:0];
        e8  = m_pos[7:0];
        e8s = m_pos8s[7:0];
        chk("ready", {rdy32, rdy8w, rdy8s}, 3'b111);
        chk("vld32", vld32, m_vld);
        chk("vld8w", vld8w, m_vld);
        chk("vld8s", vld8s, m_vld);
        chk("pos32", pos32, e32);
        chk("pos8w", pos8w, e8);
        chk("pos8s", pos8s, e8s);
        chk("err16", err16, (m_err > 65535) ? 65535 : m_err);
        chk("err8w", err8w, (m_err > 255) ? 255 : m_err);
        chk("err8s", err8s, (m_err > 255) ? 255 : m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    task automatic put(input int a, input int b);
        cur_a  = a;
        cur_b  = b;
        tvalid = 1'b1;
        tdata  = {16'(b), 16'(a)};
    endtask

    task automatic put_code(input int c);
        put(((c & 1) != 0) ? 200 : -200, ((c & 2) != 0) ? 200 : -200);
        cur_code = c;
    endtask

    function automatic void add(input int a, input int b, input bit md, input bit sg,
                                input bit cl, input longint p, input int e);
        vec_t v;
        v.a = a; v.b = b; v.mode = md; v.sign = sg; v.clr = cl; v.exp_pos = p; v.exp_err = e;
        tbl.push_back(v);
    endfunction

    function automatic void add_code(input int c, input bit sg, input bit cl,
                                     input longint p, input int e);
        add(((c & 1) != 0) ? 200 : -200, ((c & 2) != 0) ? 200 : -200, 1'b1, sg, cl, p, e);
    endfunction

    initial begin
        logic signed [15:0] r16;
        int a, b;

        // mode 0, sign 1 / sign 0, including values exactly on the thresholds
        add(-200, 0, 0, 1, 0, 0, 0);  add( 200, 0, 0, 1, 0, 0, 0);
        add(-200, 0, 0, 1, 0, 1, 0);  add( 200, 0, 0, 1, 0, 1, 0);
        add(-200, 0, 0, 1, 0, 2, 0);  add( 100, 0, 0, 1, 0, 2, 0);
        add(-100, 0, 0, 1, 0, 2, 0);  add( 200, 0, 0, 1, 0, 2, 0);
        add(-100, 0, 0, 1, 0, 2, 0);  add(-200, 0, 0, 1, 0, 3, 0);
        add( 200, 0, 0, 0, 0, 3, 0);  add(-200, 0, 0, 0, 0, 2, 0);
        add( 200, 0, 0, 0, 0, 2, 0);  add(-200, 0, 0, 0, 0, 1, 0);
        add(   0, 0, 0, 0, 0, 1, 0);
        // quadrature: clear + mode entry, forward, reverse, inverted sign, illegal jumps
        add_code(0, 1, 1, 0, 0);
        add_code(1, 1, 0, 1, 0);  add_code(3, 1, 0, 2, 0);
        add_code(2, 1, 0, 3, 0);  add_code(0, 1, 0, 4, 0);
        add_code(2, 1, 0, 3, 0);  add_code(3, 1, 0, 2, 0);
        add_code(1, 1, 0, 1, 0);  add_code(0, 1, 0, 0, 0);
        add_code(1, 0, 0, -1, 0); add_code(3, 0, 0, -2, 0);
        add_code(0, 0, 0, -2, 1); add_code(0, 0, 0, -2, 1);
        add_code(3, 0, 0, -2, 2); add_code(1, 0, 0, -1, 2);
        add_code(3, 1, 0, 0, 2);  add_code(2, 1, 0, 1, 2);
        add_code(0, 1, 0, 2, 2);  add_code(1, 1, 0, 3, 2);
        add_code(3, 1, 0, 4, 2);  add_code(2, 1, 0, 5, 2);
        add_code(0, 1, 0, 6, 2);  add_code(1, 1, 0, 7, 2);
        add_code(3, 1, 0, 8, 2);  add_code(2, 1, 0, 9, 2);
        add_code(0, 1, 0, 10, 2);
        // clear coinciding with a forward step at 10
        add_code(1, 1, 1, 0, 0);  add_code(3, 1, 0, 1, 0);
        // mode toggle: first sample after each change only loads the code
        add(200, 200, 0, 1, 0, 1, 0);
        add(-200, 200, 1, 1, 0, 1, 0);
        add_code(0, 1, 0, 2, 0);

        rst = 1'b1; mode = 1'b0; sign = 1'b1; clear = 1'b0;
        lo_t = -16'sd100; hi_t = 16'sd100;
        tvalid = 1'b0; tdata = '0; cur_code = 0;
        m_last_mode = 1'b0;
        tick();
        tick();
        chk("reset_pos", pos32, 0);
        chk("reset_vld", vld32, 0);
        chk("reset_err", err16, 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            put(tbl[i].a, tbl[i].b);
            mode  = tbl[i].mode;
            sign  = tbl[i].sign;
            clear = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d_pos", i), longint'($signed(pos32)), tbl[i].exp_pos);
            chk($sformatf("tbl%0d_err", i), err16, tbl[i].exp_err);
            chk($sformatf("tbl%0d_vld", i), vld32, 1);
        end
        clear = 1'b0;
        cur_code = 0;

        // wrap versus saturate on the 8-bit builds
        mode = 1'b1; sign = 1'b1;
        clear = 1'b1; put_code(cur_code); tick(); clear = 1'b0;
        for (int i = 0; i < 127; i++) begin put_code(fwd_next[cur_code]); tick(); end
        chk("max_8w", pos8w, 8'h7F);
        chk("max_8s", pos8s, 8'h7F);
        put_code(fwd_next[cur_code]); tick();
        chk("wrap_8w", pos8w, 8'h80);
        chk("sat_8s", pos8s, 8'h7F);
        chk("nowrap_32", pos32, 32'd128);
        put_code(rev_next[cur_code]); tick();
        chk("back_8w", pos8w, 8'h7F);
        chk("back_8s", pos8s, 8'h7E);
        clear = 1'b1; put_code(cur_code); tick(); clear = 1'b0;
        for (int i = 0; i < 128; i++) begin put_code(rev_next[cur_code]); tick(); end
        chk("min_8s", pos8s, 8'h80);
        put_code(rev_next[cur_code]); tick();
        chk("wrapneg_8w", pos8w, 8'h7F);
        chk("satneg_8s", pos8s, 8'h80);

        // illegal-transition counter saturation on the 8-bit counter
        clear = 1'b1; put_code(cur_code); tick(); clear = 1'b0;
        for (int i = 0; i < 260; i++) begin put_code(cur_code ^ 3); tick(); end
        chk("errsat_8", err8w, 8'hFF);
        chk("errsat_8s", err8s, 8'hFF);
        chk("err_16", err16, 260);

        // reset held for two cycles in the middle of counting
        for (int i = 0; i < 3; i++) begin put_code(fwd_next[cur_code]); tick(); end
        rst = 1'b1;
        put_code(fwd_next[cur_code]); tick();
        put_code(fwd_next[cur_code]); tick();
        chk("midrst_pos", pos32, 0);
        chk("midrst_vld", vld32, 0);
        chk("midrst_err", err16, 0);
        rst = 1'b0; mode = 1'b0;
        put(0, 0); tick();
        chk("postrst_pos", pos32, 0);
        chk("postrst_vld", vld32, 1);
        tvalid = 1'b0; tick();
        chk("idle_vld", vld32, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            if ($urandom_range(0, 31) == 0) sign = ~sign;
            clear = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) == 0) begin
                lo_t = 16'(int'($urandom_range(0, 600)) - 300);
                hi_t = 16'(int'($urandom_range(0, 600)) - 300);
            end
            case ($urandom_range(0, 7))
                0:       a = int'(lo_t);
                1:       a = int'(hi_t);
                2:       begin r16 = 16'($urandom); a = int'(r16); end
                default: a = int'($urandom_range(0, 800)) - 400;
            endcase
            case ($urandom_range(0, 7))
                0:       b = int'(hi_t);
                1:       b = int'(lo_t);
                default: b = int'($urandom_range(0, 800)) - 400;
            endcase
            put(a, b);
            tvalid = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
